// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM encoding and load-op bit positions for the MEM stage.
package mem_stage_pkg;
    localparam int EXC_W    = 84;
    localparam int MS2WS_W  = 32 + EXC_W + 1;
    localparam int RF_ZIP_W = 39;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    // Positions inside the one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu} vector
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    typedef struct packed {
        logic        csr_re;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] wdata;
    } rf_zip_t;
endpackage

// File: rtl/mem_stage_load_extend.sv
// Picks the byte/half/word addressed by addr_lo and sign- or zero-extends it.
// Purely combinational; yields zero when no load op bit is set.
module load_extend
    import mem_stage_pkg::*;
(
    input  logic [4:0]  ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] wdata
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    assign w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wdata = 32'h0;
        if (ld_op[LD_B])  wdata = {{24{w_byte[7]}}, w_byte};
        if (ld_op[LD_BU]) wdata = {24'h0, w_byte};
        if (ld_op[LD_H])  wdata = {{16{w_half[15]}}, w_half};
        if (ld_op[LD_HU]) wdata = {16'h0, w_half};
        if (ld_op[LD_W])  wdata = rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: holds one instruction, waits for the data-SRAM response, aligns load data.
// Latency 1 cycle (or 1 after data_ok); a response arriving while WB stalls is buffered.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                es2ms_valid,
    output logic                ms_allowin,
    input  logic [MS2WS_W-1:0]  es2ms_bus,
    input  logic [RF_ZIP_W-1:0] es_rf_zip,
    input  logic                es_mem_req,
    input  logic [4:0]          es_ld_op,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_allowin,
    output logic                ms2ws_valid,
    output logic [MS2WS_W-1:0]  ms2ws_bus,
    output logic [RF_ZIP_W-1:0] ms_rf_zip,
    output logic                ms_ld_pending,
    output logic                ms_ex,
    input  logic                wb_flush
);
    logic               r_ms_valid;
    logic [1:0]         r_state;
    logic               r_buf_valid;
    logic [31:0]        r_buf;
    logic [MS2WS_W-1:0] r_bus;
    rf_zip_t            r_rf_zip;
    logic [4:0]         r_ld_op;
    logic [1:0]         r_addr_lo;
    logic               r_need_data;

    logic               w_fire;
    logic               w_data_avail;
    logic               w_ready_go;
    logic               w_leave;
    logic               w_buf_set;
    logic [1:0]         w_state_nxt;
    logic [31:0]        w_rdata_sel;
    logic [31:0]        w_ld_wdata;
    logic [31:0]        w_final_wdata;
    rf_zip_t            w_es_zip;

    assign w_es_zip     = rf_zip_t'(es_rf_zip);
    assign w_fire       = es2ms_valid & ms_allowin;
    assign w_data_avail = r_buf_valid | ((r_state == ST_WAIT) & data_sram_data_ok);
    assign w_ready_go   = ~r_need_data | w_data_avail;
    assign ms_allowin   = (r_state != ST_DISCARD) & (~r_ms_valid | (w_ready_go & ws_allowin));
    assign ms2ws_valid  = r_ms_valid & w_ready_go & ~wb_flush;
    assign w_leave      = ms2ws_valid & ws_allowin;
    assign w_buf_set    = (r_state == ST_WAIT) & data_sram_data_ok & ~ws_allowin & ~wb_flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fire & es_mem_req) w_state_nxt = wb_flush ? ST_DISCARD : ST_WAIT;
            end
            ST_WAIT: begin
                // Response and leave in the same cycle may overlap with a new load entering
                if (data_sram_data_ok)
                    w_state_nxt = (w_fire & es_mem_req & ~wb_flush) ? ST_WAIT : ST_IDLE;
                else if (wb_flush)
                    w_state_nxt = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (data_sram_data_ok) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid  <= 1'b0;
            r_state     <= ST_IDLE;
            r_buf_valid <= 1'b0;
            r_buf       <= 32'h0;
            r_bus       <= '0;
            r_rf_zip    <= '0;
            r_ld_op     <= 5'h0;
            r_addr_lo   <= 2'h0;
            r_need_data <= 1'b0;
        end else begin
            if (wb_flush)
                r_ms_valid <= 1'b0;
            else if (ms_allowin)
                r_ms_valid <= es2ms_valid;

            if (w_fire) begin
                r_bus       <= es2ms_bus;
                r_rf_zip    <= w_es_zip;
                r_ld_op     <= es_ld_op;
                r_addr_lo   <= w_es_zip.wdata[1:0];
                r_need_data <= es_mem_req;
            end

            r_state <= w_state_nxt;

            if (wb_flush || w_leave)
                r_buf_valid <= 1'b0;
            else if (w_buf_set)
                r_buf_valid <= 1'b1;

            if (w_buf_set) r_buf <= data_sram_rdata;
        end
    end

    assign w_rdata_sel = r_buf_valid ? r_buf : data_sram_rdata;

    load_extend u_load_extend (
        .ld_op   (r_ld_op),
        .addr_lo (r_addr_lo),
        .rdata   (w_rdata_sel),
        .wdata   (w_ld_wdata)
    );

    assign w_final_wdata = (|r_ld_op) ? w_ld_wdata : r_rf_zip.wdata;
    assign ms_rf_zip     = {r_rf_zip.csr_re, r_rf_zip.rf_we & r_ms_valid, r_rf_zip.rf_waddr, w_final_wdata};
    assign ms2ws_bus     = r_bus;
    // Low exc bits are {int, brk, ine, adef, sys, ertn}; bit 0 of the bus is ale
    assign ms_ex         = r_ms_valid & ((|r_bus[6:1]) | r_bus[0]);
    assign ms_ld_pending = r_ms_valid & (|r_ld_op) & r_need_data & ~w_data_avail;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage of the in-order LoongArch core. Sits between the EX stage and the WB stage.
- Holds one instruction and waits for the data-SRAM read response when a load request was issued in EX.
- Aligns and sign/zero-extends load data, and forwards results and exception info to WB.
- Exports a bypass/stall bundle to ID and discards an orphaned SRAM response after a pipeline flush.

Parameters:
- EXC_W, 84, opaque exception/CSR bundle width, passed through unchanged: {csr_num, csr_wmask, csr_wvalue, csr_we, int, brk, ine, adef, sys, ertn}.
- MS2WS_W, 117, WB bus width = 32 (pc) + EXC_W + 1 (ale).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- es2ms_valid  in  1  EX holds a valid instruction
- ms_allowin  out  1  MEM can accept this cycle
- es2ms_bus  in  MS2WS_W  {pc, exc, ale}
- es_rf_zip  in  39  {csr_re, rf_we, rf_waddr[4:0], alu_result[31:0]}
- es_mem_req  in  1  a load request was accepted by data SRAM in EX
- es_ld_op  in  5  one-hot {ld_b, ld_h, ld_w, ld_bu, ld_hu}; all-zero means not a load
- data_sram_data_ok  in  1  read response valid
- data_sram_rdata  in  32  read data
- ws_allowin  in  1  WB can accept
- ms2ws_valid  out  1  to WB
- ms2ws_bus  out  MS2WS_W  registered {pc, exc, ale}
- ms_rf_zip  out  39  {csr_re, rf_we & ms_valid, rf_waddr, final_wdata}
- ms_ld_pending  out  1  ms_valid & load & data not yet available; ID must stall on an address match
- ms_ex  out  1  ms_valid & (any exc bit | ale | ertn); EX suppresses its store
- wb_flush  in  1  wb_ex | ertn_flush from WB

Behaviour:
- Reset: ms_valid=0, state=IDLE, buf_valid=0, all latched fields 0. Outputs follow: ms2ws_valid=0, ms_ld_pending=0, ms_ex=0, ms_allowin=1.
- Registers latch when es2ms_valid & ms_allowin. Latched fields: bus, rf_zip, ld_op, addr_lo = alu_result[1:0], and need_data = es_mem_req.
- ms_valid update, in priority order:
  1. reset → 0
  2. wb_flush → 0
  3. ms_allowin → es2ms_valid
  4. otherwise hold
- data_avail = buf_valid | (state==WAIT & data_sram_data_ok).
- ms_ready_go = ~need_data | data_avail.
- ms_allowin = (state!=DISCARD) & (~ms_valid | (ms_ready_go & ws_allowin)).
- ms2ws_valid = ms_valid & ms_ready_go & ~wb_flush.
- States:
  - IDLE → WAIT when a load with es_mem_req is latched.
  - WAIT → IDLE when data_ok arrives. If ws_allowin=0 at that point, rdata goes to the 32-bit buffer and buf_valid is set.
  - WAIT & wb_flush & ~data_ok → DISCARD.
  - DISCARD → IDLE on the next data_ok; that data is dropped and nothing is accepted until then.
  - If data_ok and wb_flush occur in the same cycle in WAIT, go to IDLE and drop the data.
- buf_valid clears when the instruction leaves MEM or on wb_flush.
- Load data: rdata_sel = buf_valid ? buf : data_sram_rdata.
  - byte = rdata_sel[8*addr_lo +: 8]
  - half = addr_lo[1] ? [31:16] : [15:0]
  - ld_b/ld_h sign-extend; ld_bu/ld_hu zero-extend; ld_w passes through.
  - Non-load: final_wdata = alu_result.
- Load with ale=1: es_mem_req is 0, so there is no wait and the instruction goes straight to WB.
- csr_re is passed through; WB substitutes the CSR read value.
- Latency: 1 cycle for non-load or zero-wait load; otherwise 1 cycle after data_ok.

Decomposition:
- Shared package holds:
  - bus widths: EXC_W, MS2WS_W, RF_ZIP_W=39
  - state encoding: IDLE=2'd0, WAIT=2'd1, DISCARD=2'd2
  - ld_op bit indices
- One combinational sub-module, load_extend: inputs ld_op, addr_lo, rdata; output wdata.

Test Plan:
- Non-load add, pc=0x1c000010, alu=0x5 → ms2ws_valid the next cycle; ms_rf_zip wdata=0x5, we=1.
- ld_b, addr_lo=3, rdata=0x80FF_1234, data_ok 2 cycles late:
  - ms_ld_pending=1 for 2 cycles, ms_allowin=0
  - then wdata=0xFFFF_FF80
- ld_hu, addr_lo=2, rdata=0x8001_0000, zero wait → wdata=0x0000_8001.
- Load waiting with wb_flush=1 and no data_ok:
  - ms_valid→0, state=DISCARD, ms_allowin=0
  - next data_ok dropped, then ms_allowin=1
  - no ms2ws_valid pulse
- data_ok while ws_allowin=0:
  - data is buffered
  - 3 cycles later ws_allowin=1 → buffered ld_w value 0xDEADBEEF delivered exactly once
- Load with ale=1, es_mem_req=0 → ms_ex=1, ms2ws_valid the next cycle, ale bit set in ms2ws_bus, no wait.
